// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the single memory port between instruction fetch and load/store.
// Data accesses win over fetches (the MEM-stage instruction is older), each
// requester is served at most once per pipeline step, and the memory read
// latency is hidden behind a single stall line. A decoded Halt parks the block
// in a terminal HALTED state until reset.
module mem_port_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    // load/store side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    // pipeline control
    input  logic              halt,
    output logic              stall,
    output logic              halted,
    // memory macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic                owner_q,     owner_d;      // 0 = fetch, 1 = data
    logic                op_write_q,  op_write_d;
    logic [2:0]          cnt_q,       cnt_d;
    logic                if_valid_q,  if_valid_d;
    logic                d_done_q,    d_done_d;
    logic                halted_q,    halted_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic d_pend;
    logic i_pend;
    logic stall_int;

    // Outstanding (not yet served this step) requests and the pipeline freeze.
    always_comb begin
        d_pend    = (d_read | d_write) & ~d_done_q;
        i_pend    = if_req & ~if_valid_q;
        stall_int = halted_q | d_pend | i_pend | (state_q == ST_BUSY);
    end

    // Next-state logic: arbitration, latency countdown and served-flag upkeep.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        op_write_d  = op_write_q;
        cnt_d       = cnt_q;
        if_valid_d  = if_valid_q;
        d_done_d    = d_done_q;
        halted_d    = halted_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        // The pipeline advances on any unstalled edge, so served flags expire.
        if (!stall_int) begin
            if_valid_d = 1'b0;
            d_done_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (d_pend) begin
                    // Simultaneous read and write resolves to a write.
                    state_d     = ST_BUSY;
                    owner_d     = 1'b1;
                    op_write_d  = d_write;
                    cnt_d       = 3'(MEM_LAT);
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_write;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_write ? d_wdata : '0;
                end else if (halt) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (i_pend) begin
                    state_d     = ST_BUSY;
                    owner_d     = 1'b0;
                    op_write_d  = 1'b0;
                    cnt_d       = 3'(MEM_LAT);
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_BUSY: begin
                // The write strobe only covers the first BUSY cycle.
                mem_we_d = 1'b0;
                cnt_d    = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    state_d     = ST_IDLE;
                    mem_en_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    op_write_d  = 1'b0;
                    cnt_d       = 3'd0;
                    if (owner_q) begin
                        d_done_d = 1'b1;
                        if (!op_write_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mem_rdata;
                    end
                end
            end
            ST_HALTED: begin
                halted_d = 1'b1;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops the bus and discards any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            op_write_q  <= 1'b0;
            cnt_q       <= 3'd0;
            if_valid_q  <= 1'b0;
            d_done_q    <= 1'b0;
            halted_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            op_write_q  <= op_write_d;
            cnt_q       <= cnt_d;
            if_valid_q  <= if_valid_d;
            d_done_q    <= d_done_d;
            halted_q    <= halted_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign d_rdata   = d_rdata_q;
    assign d_done    = d_done_q;
    assign stall     = stall_int;
    assign halted    = halted_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: random pipeline steps against a transaction-level
// reference (priority order, cycle of service, memory contents), with a
// decoupled monitor popping expected responses as the DUT presents them.
module tb_mem_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_read, d_write;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          d_done;
    logic          halt, stall, halted;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .halt(halt), .stall(stall), .halted(halted),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory macro model: data is only presented in the MEM_LAT-th enabled cycle.
    logic [DW-1:0] mem_arr [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int en_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset)        en_cnt <= 0;
        else if (!mem_en) en_cnt <= 0;
        else              en_cnt <= en_cnt + 1;
    end
    always @(posedge clk) if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    assign mem_rdata = (mem_en && en_cnt == L - 1) ? mem_arr[mem_addr]
                                                   : (32'hBAD0_0000 | {23'd0, mem_addr});

    typedef struct {
        bit            is_fetch;
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    exp_t exp_q[$];
    wr_t  wq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int bursts_total = 0;
    int we_total     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a served flag rises or a write strobes.
    initial begin
        logic prev_en, prev_d, prev_i;
        exp_t e;
        wr_t  w;
        prev_en = 0; prev_d = 0; prev_i = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_en && !prev_en) bursts_total++;
                if (mem_we) begin
                    we_total++;
                    if (wq.size() == 0) chk("mem_we_unexpected", mem_we, 0);
                    else begin
                        w = wq.pop_front();
                        chk("mem_addr_wr", mem_addr, w.addr);
                        chk("mem_wdata_wr", mem_wdata, w.data);
                    end
                end
                if (d_done && !prev_d) begin
                    if (exp_q.size() == 0) chk("d_done_unexpected", d_done, 0);
                    else begin
                        e = exp_q.pop_front();
                        $display("cycle %0d: data %s addr=%0h rdata=%08h", cyc,
                                 e.is_write ? "store" : "load", e.addr, d_rdata);
                        chk("d_order", e.is_fetch, 0);
                        chk("d_cycle", cyc, e.cyc);
                        if (!e.is_write) chk("d_rdata", d_rdata, e.data);
                    end
                end
                if (if_valid && !prev_i) begin
                    if (exp_q.size() == 0) chk("if_valid_unexpected", if_valid, 0);
                    else begin
                        e = exp_q.pop_front();
                        $display("cycle %0d: fetch addr=%0h rdata=%08h", cyc, e.addr, if_rdata);
                        chk("if_order", e.is_fetch, 1);
                        chk("if_cycle", cyc, e.cyc);
                        chk("if_rdata", if_rdata, e.data);
                    end
                end
            end
            prev_en = mem_en; prev_d = d_done; prev_i = if_valid;
        end
    end

    // One pipeline step: requests held until stall is low, expectations from the
    // reference rules (data first, each access MEM_LAT+1 cycles, one burst each).
    task automatic do_step(input bit f, input bit r, input bit w, input bit h,
                           input logic [AW-1:0] ia, input logic [AW-1:0] da,
                           input logic [DW-1:0] wd);
        int start, b0, w0, n, end_off, k;
        bit has_d;
        @(posedge clk); #1;
        if_req = f; if_addr = ia; d_read = r; d_write = w;
        d_addr = da; d_wdata = wd; halt = h;
        start = cyc; b0 = bursts_total; w0 = we_total; n = 0;
        has_d = r | w;
        if (has_d) begin
            if (w) begin
                ref_mem[da] = wd;
                exp_q.push_back('{0, 1, da, wd, start + L + 1});
                wq.push_back('{da, wd});
            end else begin
                exp_q.push_back('{0, 0, da, ref_mem[da], start + L + 1});
            end
            n++;
        end
        if (f) begin
            exp_q.push_back('{1, 0, ia, ref_mem[ia], start + (has_d ? 2*L + 2 : L + 1)});
            n++;
        end
        end_off = (has_d && f) ? 2*L + 2 : ((has_d || f) ? L + 1 : 0);
        k = 0;
        forever begin
            @(negedge clk);
            if (!stall) break;
            k++;
            if (k > 40) begin
                chk("step_timeout", stall, 0);
                break;
            end
        end
        chk("step_len", k, end_off);
        chk("bursts", bursts_total - b0, n);
        chk("we_cycles", we_total - w0, w ? 1 : 0);
    endtask

    // Idle cycle: served flags must have expired and the pipeline runs freely.
    task automatic bubble();
        @(posedge clk); #1;
        if_req = 0; d_read = 0; d_write = 0; halt = 0;
        @(negedge clk);
        chk("bubble_if_valid", if_valid, 0);
        chk("bubble_d_done", d_done, 0);
        chk("bubble_stall", stall, 0);
        chk("bubble_mem_en", mem_en, 0);
    endtask

    initial begin
        int b0, kind;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] wd;
        for (int i = 0; i < (1 << AW); i++) begin
            wd = $urandom;
            mem_arr[i] = wd;
            ref_mem[i] = wd;
        end
        mem_arr[5] = 32'h0050_0093;
        ref_mem[5] = 32'h0050_0093;
        reset = 1; if_req = 0; if_addr = 0; d_read = 0; d_write = 0;
        d_addr = 0; d_wdata = 0; halt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_valid", if_valid, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_stall", stall, 0);
        reset = 0;

        // Directed: fetch only, lw + fetch, store then load back, held load.
        do_step(1, 0, 0, 0, 9'd5, 9'd0, 32'd0);
        bubble();
        do_step(1, 1, 0, 0, 9'h04, 9'h10, 32'd0);
        bubble();
        do_step(0, 0, 1, 0, 9'd0, 9'd3, 32'hDEAD_BEEF);
        do_step(0, 1, 0, 0, 9'd0, 9'd3, 32'd0);
        do_step(0, 1, 0, 0, 9'd0, 9'd3, 32'd0);
        bubble();

        // Random pipeline steps.
        for (int s = 0; s < 150; s++) begin
            kind = $urandom_range(0, 5);
            ia = 9'($urandom_range(0, 15));
            da = 9'($urandom_range(0, 15));
            wd = $urandom;
            case (kind)
                0: do_step(1, 0, 0, 0, ia, da, wd);
                1: do_step(0, 1, 0, 0, ia, da, wd);
                2: do_step(0, 0, 1, 0, ia, da, wd);
                3: do_step(1, 1, 0, 0, ia, da, wd);
                4: do_step(1, 0, 1, 0, ia, da, wd);
                default: do_step(1, 1, 1, 0, ia, da, wd);
            endcase
            if ($urandom_range(0, 1) == 1) bubble();
        end
        bubble();

        // Halt together with a load: the load finishes, then the core stays parked.
        do_step(0, 1, 0, 1, 9'd0, 9'd3, 32'd0);
        if_req = 1; if_addr = 9'd7;
        b0 = bursts_total;
        repeat (10) begin
            @(negedge clk);
            chk("halt_halted", halted, 1);
            chk("halt_stall", stall, 1);
            chk("halt_mem_en", mem_en, 0);
        end
        chk("halt_bursts", bursts_total - b0, 0);
        @(posedge clk); #1;
        reset = 1; if_req = 0; d_read = 0; halt = 0;
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("unhalt_halted", halted, 0);
        chk("unhalt_stall", stall, 0);
        do_step(1, 0, 0, 0, 9'd5, 9'd0, 32'd0);
        bubble();

        // Reset in the second BUSY cycle of a load: bus drops, no d_done follows.
        @(posedge clk); #1;
        d_read = 1; d_addr = 9'd7;
        repeat (3) @(negedge clk);
        chk("mid_busy_mem_en", mem_en, 1);
        reset = 1; d_read = 0;
        #1;
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_d_done", d_done, 0);
        @(posedge clk); #1;
        reset = 0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_d_done", d_done, 0);
            chk("post_rst_mem_en", mem_en, 0);
        end
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction memory between the instruction-fetch (IF) path and the load/store (MEM) path of the RISC-V core. It serialises accesses with a fixed data-over-fetch priority and hides a configurable memory read latency. It drives one pipeline `stall` line and enters a terminal halted state when the decoded `Halt` control is seen. It sits between the core datapath/Controller outputs (`MemRead`, `MemWrite`, `Halt`) and the memory macro.

## Interface
- `ADDR_W`, 9: memory word-address width.
- `DATA_W`, 32: data width.
- `MEM_LAT`, 1: memory read latency in cycles. Legal range 1..4.

- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-high reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetched instruction. Valid while `if_valid`.
- `if_valid`  out  1  fetch served for the current pipeline step.
- `d_read`  in  1  load request (`MemRead`).
- `d_write`  in  1  store request (`MemWrite`).
- `d_addr`  in  ADDR_W  load/store address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data. Valid while `d_done`.
- `d_done`  out  1  data access served for the current pipeline step.
- `halt`  in  1  decoded `Halt` control.
- `stall`  out  1  freeze pipeline registers and PC.
- `halted`  out  1  core stopped.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data. Valid `MEM_LAT` cycles after `mem_en` rises.

## Operation
- **States:** IDLE, BUSY, HALTED. Internal registers:
  - owner bit (0 = fetch, 1 = data)
  - latched op/addr/wdata
  - latency counter `cnt`, width 3
  - served flags (`if_valid`, `d_done`)
  - `if_rdata`, `d_rdata` holding registers
- **Pending signals:**
  - `d_pend = (d_read | d_write) & !d_done`
  - `i_pend = if_req & !if_valid`
- **IDLE:**
  - If `d_pend`: latch data op, go to BUSY with owner = data, `cnt = MEM_LAT`. If `d_read` and `d_write` are both high, the access is a write.
  - Else if `halt`: go to HALTED.
  - Else if `i_pend`: latch fetch, go to BUSY with owner = fetch.
  - Else stay in IDLE.
- **BUSY:**
  - `mem_en = 1`. `mem_addr` and `mem_wdata` come from the latched values.
  - `mem_we = 1` only in the first BUSY cycle of a write.
  - `cnt` decrements each cycle.
  - On the edge where `cnt == 1`: capture `mem_rdata` into the owner's rdata register (writes leave `d_rdata` unchanged), set the owner's served flag, return to IDLE.
- **HALTED:** terminal until `reset`. `halted = 1`, `stall = 1`, `mem_en = 0`. Requests are ignored.
- **Stall:** `stall = halted | d_pend | i_pend | (state == BUSY)`, combinational.
- **Served flags:**
  - Held high until a cycle with `stall == 0`. They clear on that edge, because the pipeline advances and presents new requests.
  - While a flag is set, the same requester is never re-accepted, so a frozen request is served exactly once.
- **Priority:** data over fetch, because the MEM-stage instruction is older. No starvation: each requester is served at most once per pipeline step.
- `halt` never pre-empts a pending data access. `halt` arriving during BUSY is acted on in the following IDLE cycle.

## Timing
- **Reset values (asynchronous):**
  - State IDLE.
  - `if_valid`, `d_done`, `halted`, `mem_en`, `mem_we` = 0.
  - `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata` = 0.
  - `stall` = 0 when no request is present.
- **Single access:** request seen in cycle 0, BUSY in cycles 1..`MEM_LAT`, flag high and `stall = 0` in cycle `MEM_LAT+1`. Total latency `MEM_LAT+1`.
- **Both requesters pending:**
  - Data is served first, flag high in cycle `MEM_LAT+1`.
  - Fetch is accepted in that same IDLE cycle, with `stall` still 1.
  - `if_valid` rises in cycle `2*MEM_LAT+2`. `stall` falls in that cycle.
- **Write timing:** the write commits at the first BUSY edge. The write still occupies `MEM_LAT` BUSY cycles so both request types have uniform timing.
- **Reset mid-BUSY:** the transaction is discarded and no flag is set. `mem_en` drops immediately (asynchronously).
- **Idle bus:** `mem_*` outputs are 0 whenever the state is not BUSY.

## Test plan
- **Fetch only:** `MEM_LAT=1`, `if_req=1`, `if_addr=5`, `mem_rdata` model returns `0x00500093`. Required: `mem_en` high in cycle 1; `if_valid=1`, `if_rdata=0x00500093`, `stall=0` in cycle 2. The flag clears in cycle 3.
- **Simultaneous lw + fetch:** `MEM_LAT=2`, `d_read=1`, `d_addr=0x10`, `if_req=1`, `if_addr=0x04`. Required: data serviced in cycles 1-2, `d_done=1` in cycle 3, fetch BUSY in cycles 4-5, `if_valid=1` in cycle 6, `stall` high in cycles 0-5.
- **Store:** `d_write=1`, `d_addr=3`, `d_wdata=0xDEADBEEF`. Required: `mem_we=1` for exactly one cycle, with `mem_addr=3` and `mem_wdata=0xDEADBEEF`. A read of address 3 afterwards returns `0xDEADBEEF`.
- **No double service:** hold `d_read=1` across the `d_done` cycle. Required: exactly one `mem_en` burst. The next access begins only after `stall=0`.
- **Halt:** `halt=1` with `d_read=1`. Required: the load completes first, then `halted=1` and `stall=1` permanently, with no further `mem_en`. `reset` returns the block to IDLE.
- **Reset mid-access:** `MEM_LAT=3`, assert `reset` in BUSY cycle 2. Required: outputs are zero immediately and no `d_done` pulse follows.
